// File: rtl/tlc_latch_receiver.sv
// Receiver for the SCLK/SDI/LAT LED-driver protocol: oversamples the pins, assembles
// 769-bit frames and decodes them into grayscale or control latches on each LAT rise.
module tlc_latch_receiver #(
   parameter int         LATCH_SIZE = 769,
   parameter logic [7:0] CTRL_HDR   = 8'h96
) (
   input  logic                  CLK_10M,
   input  logic                  nReset,
   input  logic                  SCLK,
   input  logic                  SDI,
   input  logic                  LAT,
   output logic                  sout,
   output logic [LATCH_SIZE-2:0] gs_data,
   output logic [LATCH_SIZE-2:0] ctrl_data,
   output logic                  gs_valid,
   output logic                  ctrl_valid,
   output logic                  frame_err,
   output logic                  hdr_err,
   output logic [9:0]            bit_count
);

   localparam int          MSB       = LATCH_SIZE - 1;
   localparam logic [9:0]  COUNT_MAX = 10'h3FF;
   localparam logic [9:0]  FRAME_LEN = 10'(LATCH_SIZE);

   logic [1:0] sclk_sync, sdi_sync, lat_sync;
   logic       sclk_hist, lat_hist;
   logic       sclk_rise, lat_rise;

   logic [MSB:0] shreg, shreg_next;
   logic [9:0]   count_next;
   logic         is_ctrl, hdr_ok;

   // SDI gets the same two-stage depth as SCLK so the sampled bit lines up with its clock edge.
   // NOTE: every clocked register is written with <= so all flops see pre-edge values.
   always_ff @(posedge CLK_10M or negedge nReset) begin
      if (!nReset) begin
         sclk_sync <= '0;
         sdi_sync  <= '0;
         lat_sync  <= '0;
         sclk_hist <= 1'b0;
         lat_hist  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], SCLK};
         sdi_sync  <= {sdi_sync[0], SDI};
         lat_sync  <= {lat_sync[0], LAT};
         sclk_hist <= sclk_sync[1];
         lat_hist  <= lat_sync[1];
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_hist;
   assign lat_rise  = lat_sync[1] & ~lat_hist;

   // A shift coinciding with a latch is folded in first, so decode and length check see it.
   always_comb begin
      shreg_next = shreg;
      count_next = bit_count;
      if (sclk_rise) begin
         shreg_next = {shreg[MSB-1:0], sdi_sync[1]};
         count_next = (bit_count == COUNT_MAX) ? COUNT_MAX : bit_count + 10'd1;
      end
   end

   assign is_ctrl = shreg_next[MSB];
   assign hdr_ok  = (shreg_next[MSB-1 -: 8] == CTRL_HDR);

   // NOTE: the wide shift and payload registers are plain flops, not RAM, so they take the async clear.
   always_ff @(posedge CLK_10M or negedge nReset) begin
      if (!nReset) begin
         shreg      <= '0;
         bit_count  <= '0;
         gs_data    <= '0;
         ctrl_data  <= '0;
         gs_valid   <= 1'b0;
         ctrl_valid <= 1'b0;
         frame_err  <= 1'b0;
         hdr_err    <= 1'b0;
      end else begin
         shreg      <= shreg_next;
         gs_valid   <= 1'b0;
         ctrl_valid <= 1'b0;
         frame_err  <= 1'b0;
         hdr_err    <= 1'b0;
         if (lat_rise) begin
            bit_count <= '0;
            frame_err <= (count_next != FRAME_LEN);
            if (!is_ctrl) begin
               gs_data  <= shreg_next[MSB-1:0];
               gs_valid <= 1'b1;
            end else if (hdr_ok) begin
               ctrl_data  <= shreg_next[MSB-1:0];
               ctrl_valid <= 1'b1;
            end else begin
               hdr_err <= 1'b1;
            end
         end else begin
            bit_count <= count_next;
         end
      end
   end

   assign sout = shreg[MSB];

endmodule

// File: tb/tb_tlc_latch_receiver.sv
// Directed bench for tlc_latch_receiver: drives whole frames synchronously and checks
// latch contents, pulse widths, error flags, bit counts and pin-to-pulse latency.
module tb_tlc_latch_receiver;

   logic         CLK_10M = 1'b0;
   logic         nReset, SCLK, SDI, LAT;
   logic         sout;
   logic [767:0] gs_data, ctrl_data;
   logic         gs_valid, ctrl_valid, frame_err, hdr_err;
   logic [9:0]   bit_count;

   int checks = 0;
   int errors = 0;

   // Reference picture of the receiver built from the driven bit stream.
   logic [768:0] exp_sh;
   int           exp_cnt;
   logic [767:0] exp_gs, exp_ctrl;

   int n_gs, n_ctrl, n_ferr, n_herr, gs_rises, lat_cyc;

   tlc_latch_receiver dut (
      .CLK_10M    (CLK_10M),
      .nReset     (nReset),
      .SCLK       (SCLK),
      .SDI        (SDI),
      .LAT        (LAT),
      .sout       (sout),
      .gs_data    (gs_data),
      .ctrl_data  (ctrl_data),
      .gs_valid   (gs_valid),
      .ctrl_valid (ctrl_valid),
      .frame_err  (frame_err),
      .hdr_err    (hdr_err),
      .bit_count  (bit_count)
   );

   always #50 CLK_10M = ~CLK_10M;

   function automatic logic [768:0] ctrl_frame(input logic [7:0] hdr);
      logic [768:0] f;
      logic [4:0]   pat;
      pat        = 5'b10100;
      f[768]     = 1'b1;
      f[767:760] = hdr;
      f[759:734] = 26'h3FFFFFF;
      for (int j = 0; j < 734; j++) f[733-j] = pat[4-(j%5)];
      return f;
   endfunction

   task automatic shift_bit(input logic b);
      @(negedge CLK_10M); SDI = b; SCLK = 1'b0;
      @(negedge CLK_10M); SCLK = 1'b1;
      exp_sh  = {exp_sh[767:0], b};
      exp_cnt = (exp_cnt == 1023) ? 1023 : exp_cnt + 1;
   endtask

   task automatic shift_frame(input logic [768:0] f);
      for (int i = 768; i >= 0; i--) shift_bit(f[i]);
   endtask

   task automatic watch(input int cycles);
      logic prev;
      prev = 1'b0; n_gs = 0; n_ctrl = 0; n_ferr = 0; n_herr = 0; gs_rises = 0; lat_cyc = -1;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge CLK_10M);
         if (gs_valid) n_gs++;
         if (gs_valid && !prev) gs_rises++;
         if (ctrl_valid) n_ctrl++;
         if (frame_err) n_ferr++;
         if (hdr_err) n_herr++;
         if ((gs_valid || ctrl_valid || hdr_err) && lat_cyc < 0) lat_cyc = i;
         prev = gs_valid;
      end
   endtask

   // Raises LAT (optionally together with the final SCLK rise), holds it high for the
   // whole window and compares every output against the reference picture.
   task automatic do_latch(input string name, input bit coincide, input logic last_bit);
      int want_gs, want_ctrl, want_herr, want_ferr;
      if (coincide) begin
         @(negedge CLK_10M); SDI = last_bit; SCLK = 1'b0;
         @(negedge CLK_10M); SCLK = 1'b1; LAT = 1'b1;
         exp_sh  = {exp_sh[767:0], last_bit};
         exp_cnt = (exp_cnt == 1023) ? 1023 : exp_cnt + 1;
      end else begin
         @(negedge CLK_10M); LAT = 1'b1;
      end
      want_ferr = (exp_cnt != 769) ? 1 : 0;
      want_gs = 0; want_ctrl = 0; want_herr = 0;
      if (!exp_sh[768]) begin
         want_gs = 1; exp_gs = exp_sh[767:0];
      end else if (exp_sh[767:760] == 8'h96) begin
         want_ctrl = 1; exp_ctrl = exp_sh[767:0];
      end else begin
         want_herr = 1;
      end
      exp_cnt = 0;
      watch(8);
      checks++; if (n_gs !== want_gs) begin errors++; $display("FAIL %s gs_valid cycles got %0d want %0d", name, n_gs, want_gs); end
      checks++; if (n_ctrl !== want_ctrl) begin errors++; $display("FAIL %s ctrl_valid cycles got %0d want %0d", name, n_ctrl, want_ctrl); end
      checks++; if (n_herr !== want_herr) begin errors++; $display("FAIL %s hdr_err cycles got %0d want %0d", name, n_herr, want_herr); end
      checks++; if (n_ferr !== want_ferr) begin errors++; $display("FAIL %s frame_err cycles got %0d want %0d", name, n_ferr, want_ferr); end
      checks++; if (gs_data !== exp_gs) begin errors++; $display("FAIL %s gs_data got %h want %h", name, gs_data, exp_gs); end
      checks++; if (ctrl_data !== exp_ctrl) begin errors++; $display("FAIL %s ctrl_data got %h want %h", name, ctrl_data, exp_ctrl); end
      checks++; if (bit_count !== 10'd0) begin errors++; $display("FAIL %s bit_count after latch got %0d want 0", name, bit_count); end
      checks++; if (sout !== exp_sh[768]) begin errors++; $display("FAIL %s sout got %b want %b", name, sout, exp_sh[768]); end
      checks++; if (lat_cyc !== 3) begin errors++; $display("FAIL %s latency got %0d want 3", name, lat_cyc); end
      LAT = 1'b0; SCLK = 1'b0;
      repeat (2) @(negedge CLK_10M);
   endtask

   task automatic test_reset();
      nReset = 1'b0; SCLK = 1'b0; SDI = 1'b0; LAT = 1'b0;
      exp_sh = '0; exp_cnt = 0; exp_gs = '0; exp_ctrl = '0;
      repeat (3) @(negedge CLK_10M);
      nReset = 1'b1;
      watch(4);
      checks++; if (gs_data !== '0) begin errors++; $display("FAIL reset gs_data got %h want 0", gs_data); end
      checks++; if (ctrl_data !== '0) begin errors++; $display("FAIL reset ctrl_data got %h want 0", ctrl_data); end
      checks++; if (bit_count !== 10'd0 || sout !== 1'b0) begin errors++; $display("FAIL reset count/sout got %0d/%b want 0/0", bit_count, sout); end
      checks++; if (n_gs + n_ctrl + n_ferr + n_herr !== 0) begin errors++; $display("FAIL reset pulses got %0d want 0", n_gs + n_ctrl + n_ferr + n_herr); end
   endtask

   task automatic test_grayscale();
      shift_frame({1'b0, {768{1'b1}}});
      repeat (3) @(negedge CLK_10M);
      checks++; if (bit_count !== 10'd769) begin errors++; $display("FAIL gs bit_count got %0d want 769", bit_count); end
      do_latch("grayscale", 1'b0, 1'b0);
      checks++; if (gs_data !== {768{1'b1}} || ctrl_data !== '0) begin errors++; $display("FAIL gs_all_ones gs_data got %h ctrl %h", gs_data, ctrl_data); end
   endtask

   task automatic test_control();
      logic [768:0] f;
      f = ctrl_frame(8'h96);
      shift_frame(f);
      do_latch("control", 1'b0, 1'b0);
      checks++; if (ctrl_data !== f[767:0] || gs_data !== {768{1'b1}}) begin errors++; $display("FAIL control ctrl_data got %h want %h", ctrl_data, f[767:0]); end
   endtask

   task automatic test_bad_header();
      logic [768:0] good;
      good = ctrl_frame(8'h96);
      shift_frame(ctrl_frame(8'h95));
      do_latch("bad_header", 1'b0, 1'b0);
      checks++; if (ctrl_data !== good[767:0]) begin errors++; $display("FAIL bad_header ctrl_data changed got %h want %h", ctrl_data, good[767:0]); end
   endtask

   task automatic test_short_long();
      logic [767:0] p;
      for (int i = 0; i < 700; i++) shift_bit((i % 3) == 0);
      do_latch("short_700", 1'b0, 1'b0);
      for (int k = 0; k < 768; k++) p[k] = ((k % 7) == 0);
      for (int i = 0; i < 31; i++) shift_bit(1'b1);
      shift_frame({1'b0, p});
      do_latch("long_800", 1'b0, 1'b0);
      checks++; if (gs_data !== p) begin errors++; $display("FAIL long_800 gs_data got %h want %h", gs_data, p); end
   endtask

   task automatic test_coincident();
      logic [768:0] f;
      f = {1'b0, {384{2'b01}}};
      for (int i = 768; i >= 1; i--) shift_bit(f[i]);
      do_latch("coincident", 1'b1, f[0]);
      checks++; if (gs_data !== {384{2'b01}}) begin errors++; $display("FAIL coincident gs_data got %h want %h", gs_data, {384{2'b01}}); end
   endtask

   task automatic test_back_to_back();
      logic [767:0] p;
      logic         prev;
      p = {192{4'hC}};
      shift_frame({1'b0, p});
      @(negedge CLK_10M); LAT = 1'b1;
      prev = 1'b0; n_gs = 0; n_ferr = 0; gs_rises = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK_10M);
         if (gs_valid) n_gs++;
         if (gs_valid && !prev) gs_rises++;
         if (frame_err) n_ferr++;
         prev = gs_valid;
         if (i == 1) LAT = 1'b0;
         if (i == 2) LAT = 1'b1;
         if (i == 3) LAT = 1'b0;
      end
      exp_gs = p; exp_cnt = 0;
      checks++; if (gs_rises !== 2 || n_gs !== 2) begin errors++; $display("FAIL back_to_back gs pulses got %0d/%0d cycles want 2/2", gs_rises, n_gs); end
      checks++; if (n_ferr !== 1) begin errors++; $display("FAIL back_to_back frame_err got %0d want 1", n_ferr); end
      checks++; if (gs_data !== p) begin errors++; $display("FAIL back_to_back gs_data got %h want %h", gs_data, p); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 300; i++) shift_bit(1'b1);
      @(negedge CLK_10M); SCLK = 1'b0; nReset = 1'b0;
      #1;
      exp_sh = '0; exp_cnt = 0; exp_gs = '0; exp_ctrl = '0;
      checks++; if (ctrl_data !== '0 || gs_data !== '0 || bit_count !== 10'd0) begin errors++; $display("FAIL reset_mid immediate clear got cnt %0d", bit_count); end
      repeat (2) @(negedge CLK_10M);
      nReset = 1'b1;
      repeat (2) @(negedge CLK_10M);
      do_latch("reset_mid", 1'b0, 1'b0);
      checks++; if (gs_data !== '0 || n_ferr !== 1) begin errors++; $display("FAIL reset_mid gs_data/frame_err got %h/%0d want 0/1", gs_data, n_ferr); end
   endtask

   initial begin
      test_reset();
      test_grayscale();
      test_control();
      test_bad_header();
      test_short_long();
      test_coincident();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
